// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Column-serial AES MixColumns stage. It accepts a 128-bit post-ShiftRows
//   state over a valid/ready handshake and transforms one 32-bit column per
//   clock. It presents the registered result on a second valid/ready
//   handshake. With bypass set, the block passes through unchanged; this is
//   used for the final AES round.
//
//   Byte layout is column-major: column c = data[127-32c -: 32], and row r
//   of that column = data[127-32c-8r -: 8].
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    inp_data / bypass valid
//   in_ready   out  1    stage can accept a block (state == IDLE)
//   inp_data   in   128  post-ShiftRows state
//   bypass     in   1    skip the transform for this block
//   out_valid  out  1    mix_data valid (state == DONE)
//   out_ready  in   1    consumer accepts mix_data
//   mix_data   out  128  MixColumns result, registered
//   busy       out  1    state != IDLE
//
// States
//   IDLE | waiting for a block; in_ready high
//   CALC | one column per cycle, col 0..3
//   DONE | result held on mix_data until out_ready
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inp_data,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] mix_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_col;
  logic [127:0]  r_work;
  logic [127:0]  r_mix;
  logic [31:0]   w_col_in;
  logic [31:0]   w_col_out;
  logic          w_accept;

  // Multiply by x in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    // 3x is written as 2x ^ x.
    b0 = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
    b3 = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
    mix_col = {b0, b1, b2, b3};
  endfunction

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign mix_data  = r_mix;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_col_in = r_work[127:96];
    case (r_col)
      2'd0:    w_col_in = r_work[127:96];
      2'd1:    w_col_in = r_work[95:64];
      2'd2:    w_col_in = r_work[63:32];
      default: w_col_in = r_work[31:0];
    endcase
  end

  assign w_col_out = mix_col(w_col_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = bypass ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_col == 2'd3) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_mix  <= '0;
      r_col  <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_work <= inp_data;
            r_col  <= 2'd0;
            if (bypass) begin
              r_mix <= inp_data;
            end
          end
        end
        CALC: begin
          case (r_col)
            2'd0:    r_mix[127:96] <= w_col_out;
            2'd1:    r_mix[95:64]  <= w_col_out;
            2'd2:    r_mix[63:32]  <= w_col_out;
            default: r_mix[31:0]   <= w_col_out;
          endcase
          r_col <= r_col + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] inp_data;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] mix_data;
  logic         busy;

  int n_vec;
  int n_err;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] EDGE_IN  = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;
  localparam logic [127:0] EDGE_OUT = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp_data  (inp_data),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mix_data  (mix_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a block and wait for its acceptance edge; returns #1 after it.
  task automatic accept_blk(input logic [127:0] d, input logic byp, input string tag);
    int n;
    @(negedge clk);
    inp_data = d;
    bypass   = byp;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inp_data = ~d;
    bypass   = ~byp;
    chk({tag, "_busy_after_accept"}, {127'd0, busy}, 128'd1);
  endtask

  // Count edges after the acceptance edge until out_valid is seen.
  task automatic wait_out(input int exp_edges, input string tag);
    int edges;
    edges = 0;
    while (!out_valid && edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_latency"}, 128'(edges), 128'(exp_edges));
  endtask

  // With out_ready high, the next edge is the handshake.
  task automatic finish_blk(input logic [127:0] exp, input string tag);
    chk({tag, "_mix"}, mix_data, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_ov_after_hs"}, {127'd0, out_valid}, 128'd0);
    chk({tag, "_rdy_after_hs"}, {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inp_data  = '0;
    bypass    = 1'b0;
    out_ready = 1'b1;

    // Reset state, with in_valid asserted to show nothing is captured.
    in_valid = 1'b1;
    inp_data = FIPS_IN;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {127'd0, in_ready},  128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy",      {127'd0, busy},      128'd0);
    chk("rst_mix",       mix_data,            128'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 round 1 column vector.
    accept_blk(FIPS_IN, 1'b0, "fips");
    wait_out(4, "fips");
    finish_blk(FIPS_OUT, "fips");

    // Columns hitting the xtime reduction path and the identity columns.
    accept_blk(EDGE_IN, 1'b0, "edge");
    wait_out(4, "edge");
    finish_blk(EDGE_OUT, "edge");

    // Bypass: output equals input, valid right after acceptance.
    accept_blk(BYP_IN, 1'b1, "byp");
    wait_out(0, "byp");
    finish_blk(BYP_IN, "byp");

    // Backpressure with input noise while held in DONE.
    out_ready = 1'b0;
    accept_blk(EDGE_IN, 1'b0, "bp");
    wait_out(4, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      inp_data = {$urandom, $urandom, $urandom, $urandom};
      bypass   = i[1];
      @(posedge clk);
      #1;
      chk("bp_mix_hold", mix_data,             EDGE_OUT);
      chk("bp_ov_hold",  {127'd0, out_valid},  128'd1);
      chk("bp_rdy_low",  {127'd0, in_ready},   128'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_blk(EDGE_OUT, "bp_release");
    chk("bp_idle_busy", {127'd0, busy}, 128'd0);

    // Reset two cycles after acceptance.
    accept_blk(FIPS_IN, 1'b0, "rstmid");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ov",   {127'd0, out_valid}, 128'd0);
    chk("rstmid_mix",  mix_data,            128'd0);
    chk("rstmid_busy", {127'd0, busy},      128'd0);
    chk("rstmid_rdy",  {127'd0, in_ready},  128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    accept_blk(FIPS_IN, 1'b0, "postrst");
    wait_out(4, "postrst");
    finish_blk(FIPS_OUT, "postrst");

    // Back-to-back: in_valid stays high across both blocks.
    out_ready = 1'b1;
    @(negedge clk);
    inp_data = FIPS_IN;
    bypass   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    inp_data = EDGE_IN;
    chk("b2b_a_busy", {127'd0, busy}, 128'd1);
    wait_out(4, "b2b_a");
    chk("b2b_a_mix", mix_data, FIPS_OUT);
    @(posedge clk);
    #1;
    chk("b2b_hs_rdy", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inp_data = '0;
    chk("b2b_b_accept", {127'd0, busy}, 128'd1);
    wait_out(4, "b2b_b");
    finish_blk(EDGE_OUT, "b2b_b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
